// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: state encoding, the
// stage enable/flush bundle and small helpers that build the common bundles.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MISS_WAIT = 2'd1,
      RESUME    = 2'd2
   } pipe_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_bubble;
   } stage_ctrl_t;

   function automatic stage_ctrl_t ctrl_reset();
      stage_ctrl_t c;
      c              = '0;
      c.ifid_flush   = 1'b1;
      c.idex_flush   = 1'b1;
      c.memwb_bubble = 1'b1;
      return c;
   endfunction

   // Pipe frozen behind a cache miss: only MEM/WB moves, and it takes a bubble.
   function automatic stage_ctrl_t ctrl_frozen();
      stage_ctrl_t c;
      c              = '0;
      c.memwb_en     = 1'b1;
      c.memwb_bubble = 1'b1;
      return c;
   endfunction

   function automatic stage_ctrl_t ctrl_flow(input logic branch, input logic lu);
      stage_ctrl_t c;
      c              = '0;
      c.pc_en        = 1'b1;
      c.ifid_en      = 1'b1;
      c.idex_en      = 1'b1;
      c.exmem_en     = 1'b1;
      c.memwb_en     = 1'b1;
      if (branch) begin
         c.ifid_flush = 1'b1;
         c.idex_flush = 1'b1;
      end else if (lu) begin
         c.pc_en      = 1'b0;
         c.ifid_en    = 1'b0;
         c.idex_flush = 1'b1;
      end
      return c;
   endfunction

   function automatic logic load_use(input logic       mem_read,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
      return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Synchronous-clear up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: cache-miss freeze, load-use
// bubble and taken-branch squash, plus stall/flush counters and miss timeout.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int MISS_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_req,
   input  logic             hit,
   input  logic             refill_done,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             branch_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             timeout_err,
   output logic             in_miss
);

   localparam int MW = $clog2(MISS_TIMEOUT + 1);
   localparam logic [MW-1:0] MISS_LIMIT = MW'(MISS_TIMEOUT);

   pipe_state_e state, state_next;
   stage_ctrl_t ctrl;
   logic [MW-1:0] miss_cnt, miss_cnt_next;
   logic miss, lu;

   assign miss = mem_req & ~hit;
   assign lu   = load_use(ex_mem_read, ex_rd, id_rs1, id_rs2);

   // RESUME uses the same flow rules as RUN but never re-enters the miss.
   always_comb begin
      ctrl          = ctrl_reset();
      state_next    = state;
      miss_cnt_next = miss_cnt;
      if (!rst) begin
         case (state)
            RUN: begin
               if (miss) begin
                  ctrl          = ctrl_frozen();
                  state_next    = MISS_WAIT;
                  miss_cnt_next = '0;
               end else begin
                  ctrl = ctrl_flow(branch_taken, lu);
               end
            end
            MISS_WAIT: begin
               ctrl = ctrl_frozen();
               if (miss_cnt != MISS_LIMIT)
                  miss_cnt_next = miss_cnt + 1'b1;
               if (refill_done)
                  state_next = RESUME;
            end
            RESUME: begin
               ctrl       = ctrl_flow(branch_taken, lu);
               state_next = RUN;
            end
            default: begin
               ctrl       = ctrl_reset();
               state_next = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         miss_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state    <= state_next;
         miss_cnt <= miss_cnt_next;
         if ((state == MISS_WAIT) && (miss_cnt_next == MISS_LIMIT))
            timeout_err <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (~ctrl.pc_en),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (ctrl.ifid_flush),
      .count (flush_cnt)
   );

   assign pc_en        = ctrl.pc_en;
   assign ifid_en      = ctrl.ifid_en;
   assign idex_en      = ctrl.idex_en;
   assign exmem_en     = ctrl.exmem_en;
   assign memwb_en     = ctrl.memwb_en;
   assign ifid_flush   = ctrl.ifid_flush;
   assign idex_flush   = ctrl.idex_flush;
   assign memwb_bubble = ctrl.memwb_bubble;
   assign in_miss      = (state == MISS_WAIT);

endmodule
